// File: rtl/terminal_row_fetch.sv
`default_nettype none
// ============================================================================
// Module   : terminal_row_fetch
// Purpose  : Fetches one scrolled text row of 32-bit cells from SDRAM into a
//            double-banked line buffer, blank-padding short bursts.
// Revision : 1.0
// ============================================================================
module terminal_row_fetch #(
    parameter int          COLUMNS    = 80,
    parameter int          ROWS       = 51,
    parameter logic [31:0] BLANK_CELL = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [5:0]  fetch_row,
    input  logic [5:0]  first_row,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_overrun,
    output logic        fetch_bank,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done,
    output logic        buf_wr_en,
    output logic [7:0]  buf_wr_addr,
    output logic [31:0] buf_wr_data
);

    localparam logic [6:0] COLS_C = 7'(COLUMNS);
    localparam logic [6:0] ROWS_C = 7'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_RECEIVE = 3'd2,
        S_PAD     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  column_q, column_d;
    logic        wbank_q, wbank_d;
    logic        bank_q, bank_d;
    logic        busy_q, busy_d;
    logic [22:0] addr_q, addr_d;

    logic [6:0]  pr_sum;
    logic [5:0]  pr_row;
    logic [6:0]  column_inc;

    // Scroll offset is only sampled here, in the accepting IDLE cycle.
    assign pr_sum = {1'b0, fetch_row} + {1'b0, first_row};
    assign pr_row = (pr_sum >= ROWS_C) ? 6'(pr_sum - ROWS_C) : pr_sum[5:0];

    assign fetch_busy      = busy_q;
    assign fetch_bank      = bank_q;
    assign rd_address      = addr_q;
    assign rd_burst_length = 9'(COLUMNS);
    assign fetch_overrun   = fetch_start & busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            column_q <= '0;
            wbank_q  <= 1'b0;
            bank_q   <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            column_q <= column_d;
            wbank_q  <= wbank_d;
            bank_q   <= bank_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        column_d    = column_q;
        wbank_d     = wbank_q;
        bank_d      = bank_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        column_inc  = column_q;
        rd_request  = 1'b0;
        fetch_done  = 1'b0;
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    column_d = '0;
                    busy_d   = 1'b1;
                    // Out-of-range rows skip SDRAM and produce a blank line.
                    if ({1'b0, fetch_row} >= ROWS_C) begin
                        state_d = S_PAD;
                    end else begin
                        addr_d  = {8'b0, pr_row, 9'b0};
                        state_d = S_REQUEST;
                    end
                end
            end
            S_REQUEST: begin
                rd_request = 1'b1;
                state_d    = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (rd_data_valid && (column_q < COLS_C)) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_addr = {wbank_q, column_q};
                    buf_wr_data = rd_data;
                    column_inc  = column_q + 7'd1;
                end
                column_d = column_inc;
                if (rd_done) begin
                    state_d = (column_inc == COLS_C) ? S_DONE : S_PAD;
                end
            end
            S_PAD: begin
                buf_wr_en   = 1'b1;
                buf_wr_addr = {wbank_q, column_q};
                buf_wr_data = BLANK_CELL;
                if (column_q >= COLS_C - 7'd1) begin
                    state_d = S_DONE;
                end else begin
                    column_d = column_q + 7'd1;
                end
            end
            S_DONE: begin
                fetch_done = 1'b1;
                bank_d     = wbank_q;
                wbank_d    = ~wbank_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_terminal_row_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_terminal_row_fetch
// Purpose  : Randomized self-checking bench for terminal_row_fetch with an
//            SDRAM responder and a row/bank/contents reference model.
// Revision : 1.0
// ============================================================================
module tb_terminal_row_fetch;

    localparam int          COLUMNS = 80;
    localparam int          ROWS    = 51;
    localparam logic [31:0] BLANK   = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [5:0]  fetch_row;
    logic [5:0]  first_row;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_overrun;
    logic        fetch_bank;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic        buf_wr_en;
    logic [7:0]  buf_wr_addr;
    logic [31:0] buf_wr_data;

    terminal_row_fetch #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .BLANK_CELL(BLANK)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_start(fetch_start), .fetch_row(fetch_row), .first_row(first_row),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .fetch_overrun(fetch_overrun), .fetch_bank(fetch_bank),
        .rd_address(rd_address), .rd_request(rd_request),
        .rd_burst_length(rd_burst_length),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_bank = 0;

    // Observations captured by run_fetch (cycle 0 = start cycle).
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] sent_q[$];
    int          req_count, req_cyc, done_cyc, done_in_cyc, last_wr_cyc, ov_count;
    logic [22:0] req_addr;
    logic        bank_after, busy_after, busy_mid;
    bit          timed_out;

    typedef struct {
        int row; int first; int nvalid; bit same; bit gaps; bit ov;
    } fetch_t;

    task automatic apply_reset();
        reset = 1'b1; fetch_start = 1'b0; fetch_row = '0; first_row = '0;
        rd_data = '0; rd_data_valid = 1'b0; rd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives one fetch and plays the SDRAM side; records what the DUT did.
    task automatic run_fetch(input int row, input int first, input int nvalid,
                             input bit same, input bit gaps, input bit ov);
        int  sent;
        bit  done_sent;
        int  cyc;
        wr_addr_q.delete(); wr_data_q.delete(); sent_q.delete();
        req_count = 0; req_cyc = -1; done_cyc = -1; done_in_cyc = -1;
        last_wr_cyc = -1; ov_count = 0; timed_out = 0; busy_mid = 1'b0;
        sent = 0; done_sent = 0; cyc = 0;
        @(posedge clk); #1;
        fetch_start = 1'b1; fetch_row = 6'(row); first_row = 6'(first);
        rd_data_valid = 1'b0; rd_done = 1'b0;
        #1;
        if (fetch_overrun) ov_count++;
        while (done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            fetch_start = (ov && cyc == 3);
            fetch_row   = 6'($urandom);
            first_row   = 6'($urandom);
            rd_data_valid = 1'b0; rd_done = 1'b0; rd_data = $urandom;
            if (req_cyc >= 0 && !done_sent) begin
                if (sent < nvalid && !(gaps && $urandom_range(0, 3) == 0)) begin
                    rd_data_valid = 1'b1;
                    sent_q.push_back(rd_data);
                    sent++;
                    if (same && sent == nvalid) rd_done = 1'b1;
                end else if (sent >= nvalid) begin
                    rd_done = 1'b1;
                end
                if (rd_done) begin done_sent = 1; done_in_cyc = cyc; end
            end
            #1;
            if (cyc == 1) busy_mid = fetch_busy;
            if (rd_request) begin req_count++; req_cyc = cyc; req_addr = rd_address; end
            if (buf_wr_en) begin
                wr_addr_q.push_back(int'(buf_wr_addr));
                wr_data_q.push_back(buf_wr_data);
                last_wr_cyc = cyc;
            end
            if (fetch_overrun) ov_count++;
            if (fetch_done) done_cyc = cyc;
            if (cyc >= 400) begin timed_out = 1; break; end
        end
        fetch_start = 1'b0; rd_data_valid = 1'b0; rd_done = 1'b0;
        @(posedge clk); #2;
        bank_after = fetch_bank;
        busy_after = fetch_busy;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if ({fetch_busy, fetch_done, fetch_overrun, fetch_bank, rd_request, buf_wr_en} !== 6'b0)
            $display("FAIL reset_flags got %b required 000000",
                     {fetch_busy, fetch_done, fetch_overrun, fetch_bank, rd_request, buf_wr_en});
        else n_pass++;
        n_checks++;
        if (rd_address !== 23'h0) $display("FAIL reset_addr got %h required 0", rd_address);
        else n_pass++;
        n_checks++;
        if (rd_burst_length !== 9'd80) $display("FAIL reset_burst got %0d required 80", rd_burst_length);
        else n_pass++;
        n_checks++;
        if (buf_wr_addr !== 8'h0 || buf_wr_data !== 32'h0)
            $display("FAIL reset_buf got %h/%h required 0/0", buf_wr_addr, buf_wr_data);
        else n_pass++;
        #1 reset = 1'b0;
        exp_bank = 0;
    endtask

    task automatic test_fetches();
        fetch_t tbl[$];
        tbl.push_back('{0, 0, 80, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 50, 80, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{10, 5, 60, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{7, 0, 85, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{20, 30, 80, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{51, 0, 0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{50, 50, 0, 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < 10; k++)
            tbl.push_back('{($urandom_range(0, 7) == 0) ? int'($urandom_range(51, 63))
                                                        : int'($urandom_range(0, 50)),
                            int'($urandom_range(0, 50)), int'($urandom_range(0, 90)),
                            1'($urandom), 1'($urandom), 1'($urandom)});

        foreach (tbl[t]) begin
            fetch_t      f;
            bit          in_range;
            int          pr, nstore, bad, exp_done;
            int          bad_ea;
            logic [31:0] bad_ed;
            f = tbl[t];
            in_range = (f.row < ROWS);
            pr = f.row + f.first;
            if (pr >= ROWS) pr -= ROWS;
            nstore = in_range ? ((f.nvalid < COLUMNS) ? f.nvalid : COLUMNS) : 0;
            run_fetch(f.row, f.first, f.nvalid, f.same, f.gaps, f.ov);

            n_checks++;
            if (timed_out) $display("FAIL timeout fetch %0d got no fetch_done required done", t);
            else n_pass++;
            n_checks++;
            if (req_count != (in_range ? 1 : 0))
                $display("FAIL req_count fetch %0d got %0d required %0d", t, req_count, in_range ? 1 : 0);
            else n_pass++;
            if (in_range) begin
                n_checks++;
                if (req_cyc != 1 || req_addr !== 23'(pr * 512))
                    $display("FAIL req fetch %0d got cyc %0d addr %h required cyc 1 addr %h",
                             t, req_cyc, req_addr, 23'(pr * 512));
                else n_pass++;
            end
            n_checks++;
            if (wr_addr_q.size() != COLUMNS)
                $display("FAIL wr_count fetch %0d got %0d required %0d", t, wr_addr_q.size(), COLUMNS);
            else n_pass++;
            bad = -1; bad_ea = 0; bad_ed = '0;
            for (int i = 0; i < wr_addr_q.size() && i < COLUMNS; i++) begin
                int          ea;
                logic [31:0] ed;
                ea = exp_bank * 128 + i;
                ed = (i < nstore && i < sent_q.size()) ? sent_q[i] : BLANK;
                if (bad < 0 && (wr_addr_q[i] != ea || wr_data_q[i] !== ed)) begin
                    bad = i; bad_ea = ea; bad_ed = ed;
                end
            end
            n_checks++;
            if (bad >= 0)
                $display("FAIL wr_content fetch %0d idx %0d got %h/%h required %h/%h",
                         t, bad, wr_addr_q[bad], wr_data_q[bad], bad_ea, bad_ed);
            else n_pass++;
            exp_done = ((last_wr_cyc > done_in_cyc) ? last_wr_cyc : done_in_cyc) + 1;
            n_checks++;
            if (done_cyc != exp_done)
                $display("FAIL done_latency fetch %0d got %0d required %0d", t, done_cyc, exp_done);
            else n_pass++;
            n_checks++;
            if (ov_count != int'(f.ov))
                $display("FAIL overrun fetch %0d got %0d required %0d", t, ov_count, f.ov);
            else n_pass++;
            n_checks++;
            if (bank_after !== 1'(exp_bank) || busy_after !== 1'b0 || busy_mid !== 1'b1)
                $display("FAIL bank_busy fetch %0d got bank %b busy %b/%b required bank %0d busy 1/0",
                         t, bank_after, busy_mid, busy_after, exp_bank);
            else n_pass++;
            exp_bank ^= 1;
        end
    endtask

    task automatic test_reset_abort();
        int writes_before, writes_after, dones_after, reqs_after;
        writes_before = 0; writes_after = 0; dones_after = 0; reqs_after = 0;
        @(posedge clk); #1;
        fetch_start = 1'b1; fetch_row = 6'd5; first_row = 6'd0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(posedge clk); #1;
            fetch_start = 1'b0; reset = (cyc == 12);
            rd_data = $urandom;
            rd_data_valid = ((cyc >= 2 && cyc <= 11) || cyc >= 13);
            rd_done = (cyc == 18);
            #1;
            if (cyc == 13) begin
                n_checks++;
                if (fetch_busy !== 1'b0) $display("FAIL abort_busy got %b required 0", fetch_busy);
                else n_pass++;
            end
            if (cyc <= 12 && buf_wr_en) writes_before++;
            if (cyc >= 13) begin
                if (buf_wr_en)  writes_after++;
                if (fetch_done) dones_after++;
                if (rd_request) reqs_after++;
            end
        end
        rd_data_valid = 1'b0; rd_done = 1'b0; reset = 1'b0;
        n_checks++;
        if (writes_before != 10) $display("FAIL abort_pre_writes got %0d required 10", writes_before);
        else n_pass++;
        n_checks++;
        if (writes_after + dones_after + reqs_after != 0)
            $display("FAIL abort_late got %0d/%0d/%0d required 0/0/0", writes_after, dones_after, reqs_after);
        else n_pass++;
        exp_bank = 0;
        run_fetch(9, 0, 80, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[0] != 0 || bank_after !== 1'b0 || timed_out)
            $display("FAIL abort_new_bank got first_addr %0d bank %b required 0/0",
                     (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, bank_after);
        else n_pass++;
        exp_bank = 1;
    endtask

    initial begin
        test_reset();
        test_fetches();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
